// File: rtl/mist1032isa_uart_transmitter_ex_if.sv
// mist1032isa_uart_transmitter_ex_if
// Bus-side handshake bundle for the buffered UART transmitter.
//   iTX_REQ      write strobe, one FIFO entry per cycle high
//   iTX_DATA     write data, DATA_BITS wide
//   oTX_FULL     FIFO holds 2^FIFO_DEPTH_N entries
//   oTX_BUSY     FIFO non-empty or frame engine active
//   oFIFO_COUNT  current FIFO occupancy
// master: the bus side that writes bytes; slave: the transmitter.
interface mist1032isa_uart_transmitter_ex_if #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH_N = 4
);
  logic                    iTX_REQ;
  logic [DATA_BITS-1:0]    iTX_DATA;
  logic                    oTX_FULL;
  logic                    oTX_BUSY;
  logic [FIFO_DEPTH_N:0]   oFIFO_COUNT;

  modport master (
    output iTX_REQ, iTX_DATA,
    input  oTX_FULL, oTX_BUSY, oFIFO_COUNT
  );

  modport slave (
    input  iTX_REQ, iTX_DATA,
    output oTX_FULL, oTX_BUSY, oFIFO_COUNT
  );
endinterface

// File: rtl/mist1032isa_uart_transmitter_ex.sv
// mist1032isa_uart_transmitter_ex
// Buffered, runtime-configurable UART transmitter in a single clock domain.
// A circular FIFO accepts bytes from the bus; a frame engine serialises them
// as start, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stops.
// Ports:
//   iCLOCK          sole clock, rising edge
//   iRESET_SYNC     synchronous active-high reset
//   iEXTBAUD_COUNT  runtime bit period minus one (BAUDRATE_FIXED=0)
//   iPARITY_EN      append a parity bit
//   iPARITY_ODD     odd parity when 1, even when 0
//   iSTOP2          two stop bits when 1
//   iBREAK          line break request (only with MIST1032ISA_UART_TX_BREAK_EN)
//   bus             handshake bundle (request/data in, full/busy/count out)
//   oUART_TXD       registered serial line, idle high
// Optional feature macro: MIST1032ISA_UART_TX_BREAK_EN adds iBREAK and a
// BREAK state that holds the line low between frames.
module mist1032isa_uart_transmitter_ex #(
  parameter int          DATA_BITS        = 8,
  parameter int          FIFO_DEPTH_N     = 4,
  parameter logic        BAUDRATE_FIXED   = 1'b1,
  parameter logic [19:0] BAUDRATE_COUNTER = 20'd433
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic [19:0] iEXTBAUD_COUNT,
  input  logic        iPARITY_EN,
  input  logic        iPARITY_ODD,
  input  logic        iSTOP2,
`ifdef MIST1032ISA_UART_TX_BREAK_EN
  input  logic        iBREAK,
`endif
  mist1032isa_uart_transmitter_ex_if.slave bus,
  output logic        oUART_TXD
);

  localparam int          DEPTH    = 1 << FIFO_DEPTH_N;
  localparam int          CW       = FIFO_DEPTH_N + 1;
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef MIST1032ISA_UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } state_t;

  logic [DATA_BITS-1:0]    mem_q [DEPTH];
  logic [FIFO_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  state_t                  state_q, state_d;
  logic [19:0]             baud_cnt_q, baud_cnt_d;
  logic [19:0]             period_q, period_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    stop2_q, stop2_d;
  logic                    stop_idx_q, stop_idx_d;
  logic                    txd_q, txd_d;
`ifdef MIST1032ISA_UART_TX_BREAK_EN
  logic                    brk_done_q, brk_done_d;
`endif

  logic                    full, fifo_empty, push, pop, load, bit_end;
  logic [19:0]             period_eff;
  logic [DATA_BITS-1:0]    head;

  assign full       = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.iTX_REQ && !full;
  assign head       = mem_q[rd_ptr_q];
  assign period_eff = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;
  assign bit_end    = (baud_cnt_q == period_q);

  // FIFO bookkeeping: pointers wrap naturally at their width; a push and
  // pop in the same cycle leave the occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_DEPTH_N'(push);
    rd_ptr_d = rd_ptr_q + FIFO_DEPTH_N'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame engine next state. The line value is computed for the state being
  // entered so that oUART_TXD is a flop aligned with the state register.
  // A frame load (from IDLE or straight out of STOP) also snapshots the
  // configuration so mid-frame changes only affect the following frame.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = (state_q == ST_IDLE) ? 20'd0 :
                 (bit_end ? 20'd0 : baud_cnt_q + 20'd1);
    period_d   = period_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    load       = 1'b0;
`ifdef MIST1032ISA_UART_TX_BREAK_EN
    brk_done_d = brk_done_q;
`endif
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
`ifdef MIST1032ISA_UART_TX_BREAK_EN
        if (iBREAK) begin
          state_d    = ST_BREAK;
          txd_d      = 1'b0;
          period_d   = period_eff;
          baud_cnt_d = 20'd0;
          brk_done_d = 1'b0;
        end else
`endif
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              txd_d      = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
`ifdef MIST1032ISA_UART_TX_BREAK_EN
      // Break lasts at least one full bit period, then until iBREAK drops.
      ST_BREAK: begin
        txd_d = 1'b0;
        if (bit_end) brk_done_d = 1'b1;
        if (!iBREAK && (brk_done_q || bit_end)) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      txd_d      = 1'b0;
      shift_d    = head;
      par_en_d   = iPARITY_EN;
      par_bit_d  = (^head) ^ iPARITY_ODD;
      stop2_d    = iSTOP2;
      period_d   = period_eff;
      baud_cnt_d = 20'd0;
    end
  end

  // FIFO storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge iCLOCK) begin
    if (push && !iRESET_SYNC) mem_q[wr_ptr_q] <= bus.iTX_DATA;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      period_q   <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
`ifdef MIST1032ISA_UART_TX_BREAK_EN
      brk_done_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      period_q   <= period_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
`ifdef MIST1032ISA_UART_TX_BREAK_EN
      brk_done_q <= brk_done_d;
`endif
    end
  end

  assign oUART_TXD       = txd_q;
  assign bus.oTX_FULL    = full;
  assign bus.oTX_BUSY    = !fifo_empty || (state_q != ST_IDLE);
  assign bus.oFIFO_COUNT = count_q;

endmodule
